// File: rtl/demux2_buf.sv
// Registered 1-to-2 demultiplexer: one valid/ready input stream steered by ctrl
// into two independent per-channel FIFOs, each with its own valid/ready output.

module demux2_buf_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       ready,
   output logic [WIDTH-1:0]           rdata,
   output logic                       valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop;

   assign valid = (level != '0);
   assign full  = (level == FULL_LEVEL);
   assign pop   = valid && ready;
   assign rdata = mem[rd_ptr];

   // Storage is cleared on reset so the idle data output is deterministic;
   // pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
      end
   end

endmodule

module demux2_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       ctrl,
   output logic [WIDTH-1:0]           a,
   output logic                       a_valid,
   input  logic                       a_ready,
   output logic [$clog2(DEPTH):0]     a_level,
   output logic [WIDTH-1:0]           b,
   output logic                       b_valid,
   input  logic                       b_ready,
   output logic [$clog2(DEPTH):0]     b_level
);

   logic a_full;
   logic b_full;
   logic push_a;
   logic push_b;

   // Readiness looks only at the addressed FIFO's registered fullness, so a pop
   // in the same cycle never frees a slot for the incoming word.
   assign in_ready = ctrl ? !b_full : !a_full;
   assign push_a   = in_valid && in_ready && !ctrl;
   assign push_b   = in_valid && in_ready &&  ctrl;

   demux2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_a (
      .clk   (clk),
      .rst   (rst),
      .push  (push_a),
      .wdata (in),
      .ready (a_ready),
      .rdata (a),
      .valid (a_valid),
      .level (a_level),
      .full  (a_full)
   );

   demux2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_b (
      .clk   (clk),
      .rst   (rst),
      .push  (push_b),
      .wdata (in),
      .ready (b_ready),
      .rdata (b),
      .valid (b_valid),
      .level (b_level),
      .full  (b_full)
   );

endmodule

// File: tb/tb_demux2_buf.sv
// Directed, table-driven bench for demux2_buf (WIDTH=32, DEPTH=2): each record
// gives one cycle of inputs, the expected in_ready before the edge and outputs after it.

module tb_demux2_buf;

   logic        clk;
   logic        rst;
   logic [31:0] in;
   logic        in_valid;
   logic        in_ready;
   logic        ctrl;
   logic [31:0] a;
   logic        a_valid;
   logic        a_ready;
   logic [1:0]  a_level;
   logic [31:0] b;
   logic        b_valid;
   logic        b_ready;
   logic [1:0]  b_level;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic        rst;
      logic        iv;
      logic        ctrl;
      logic [31:0] din;
      logic        ar;
      logic        br;
      logic        chkIr;
      logic        expIr;
      logic        chkA;
      logic [31:0] expA;
      logic        expAv;
      logic [1:0]  expAl;
      logic        chkB;
      logic [31:0] expB;
      logic        expBv;
      logic [1:0]  expBl;
   } vec_t;

   vec_t vecs[$];

   demux2_buf #(.WIDTH(32), .DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ctrl     (ctrl),
      .a        (a),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_level  (a_level),
      .b        (b),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_level  (b_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic r, input logic iv, input logic c, input logic [31:0] d,
      input logic ar, input logic br, input logic chkIr, input logic ir,
      input logic chkA, input logic [31:0] ea, input logic eav, input logic [1:0] eal,
      input logic chkB, input logic [31:0] eb, input logic ebv, input logic [1:0] ebl);
      vec_t v;
      v.rst = r;   v.iv = iv;     v.ctrl = c;  v.din = d;
      v.ar = ar;   v.br = br;     v.chkIr = chkIr; v.expIr = ir;
      v.chkA = chkA; v.expA = ea; v.expAv = eav; v.expAl = eal;
      v.chkB = chkB; v.expB = eb; v.expBv = ebv; v.expBl = ebl;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, idx, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      rst      = v.rst;
      in_valid = v.iv;
      ctrl     = v.ctrl;
      in       = v.din;
      a_ready  = v.ar;
      b_ready  = v.br;
      #1;
      if (v.chkIr) checkOutput("in_ready", idx, 32'(in_ready), 32'(v.expIr));
      @(posedge clk);
      #1;
      if (v.chkA) checkOutput("a", idx, a, v.expA);
      checkOutput("a_valid", idx, 32'(a_valid), 32'(v.expAv));
      checkOutput("a_level", idx, 32'(a_level), 32'(v.expAl));
      if (v.chkB) checkOutput("b", idx, b, v.expB);
      checkOutput("b_valid", idx, 32'(b_valid), 32'(v.expBv));
      checkOutput("b_level", idx, 32'(b_level), 32'(v.expBl));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; ctrl = 1'b0; in = '0; a_ready = 1'b0; b_ready = 1'b0;

      // Reset held two cycles with a pushing input; nothing may be stored.
      vecs.push_back(mk(1,1,0,32'hFFFF_FFFF,0,0, 0,0, 1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(1,1,0,32'hFFFF_FFFF,0,0, 1,1, 1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(0,0,1,0,0,0,           1,1, 1,0,0,0, 1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,           1,1, 1,0,0,0, 1,0,0,0));
      // Basic steering.
      vecs.push_back(mk(0,1,0,32'h0,1,1, 1,1, 1,32'h0,1,1, 1,0,0,0));
      vecs.push_back(mk(0,1,1,32'h1,1,1, 1,1, 0,0,0,0,     1,32'h1,1,1));
      vecs.push_back(mk(0,0,0,0,0,1,     1,1, 0,0,0,0,     0,0,0,0));
      // Fill and block on channel a, b still accepts.
      vecs.push_back(mk(0,1,0,32'h10,0,0, 1,1, 1,32'h10,1,1, 0,0,0,0));
      vecs.push_back(mk(0,1,0,32'h11,0,0, 1,1, 1,32'h10,1,2, 0,0,0,0));
      vecs.push_back(mk(0,1,0,32'h12,0,0, 1,0, 1,32'h10,1,2, 0,0,0,0));
      vecs.push_back(mk(0,1,1,32'h20,0,0, 1,1, 1,32'h10,1,2, 1,32'h20,1,1));
      vecs.push_back(mk(0,0,0,0,1,1,      1,0, 1,32'h11,1,1, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0,      1,1, 0,0,0,0,      0,0,0,0));
      // Streaming with wrap-around on channel a.
      for (int k = 0; k < 8; k++) begin
         vecs.push_back(mk(0,1,0,32'h100 + 32'(k),1,0, 1,1, 1,32'h100 + 32'(k),1,1, 0,0,0,0));
      end
      vecs.push_back(mk(0,0,0,0,1,0, 1,1, 0,0,0,0, 0,0,0,0));
      // Push to full channel b while it pops: refused, level drops to 1.
      vecs.push_back(mk(0,1,1,32'h30,0,0, 1,1, 0,0,0,0, 1,32'h30,1,1));
      vecs.push_back(mk(0,1,1,32'h31,0,0, 1,1, 0,0,0,0, 1,32'h30,1,2));
      vecs.push_back(mk(0,1,1,32'h32,0,1, 1,0, 0,0,0,0, 1,32'h31,1,1));
      vecs.push_back(mk(0,1,1,32'h33,0,1, 1,1, 0,0,0,0, 1,32'h33,1,1));
      // Reset in the middle of a push with a_level=2, b_level=1.
      vecs.push_back(mk(0,1,0,32'h40,0,0, 1,1, 1,32'h40,1,1, 1,32'h33,1,1));
      vecs.push_back(mk(0,1,0,32'h41,0,0, 1,1, 1,32'h40,1,2, 1,32'h33,1,1));
      vecs.push_back(mk(1,1,1,32'h50,0,0, 1,1, 1,0,0,0,      1,0,0,0));
      vecs.push_back(mk(0,0,1,0,0,0,      1,1, 1,0,0,0,      1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,      1,1, 1,0,0,0,      1,0,0,0));

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Hand-written: channel a held full while b streams freely, then a word
      // addressed to the full a is refused.
      applyStimulus(mk(0,1,0,32'hA0,0,0, 1,1, 1,32'hA0,1,1, 0,0,0,0), 100);
      applyStimulus(mk(0,1,0,32'hA1,0,0, 1,1, 1,32'hA0,1,2, 0,0,0,0), 101);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mk(0,1,1,32'hB0 + 32'(i),0,1, 1,1, 1,32'hA0,1,2, 1,32'hB0 + 32'(i),1,1), 102 + i);
      end
      applyStimulus(mk(0,1,0,32'hA2,0,1, 1,0, 1,32'hA0,1,2, 0,0,0,0), 106);
      applyStimulus(mk(0,0,0,0,1,0,      1,0, 1,32'hA1,1,1, 0,0,0,0), 107);
      applyStimulus(mk(0,0,0,0,1,0,      1,1, 0,0,0,0,      0,0,0,0), 108);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
